// File: rtl/mark_clock_monitor_pkg.sv
// Shared encodings for the mark-step clock monitor: fault codes and FSM states,
// visible to both the RTL and bench-side decoders.
package mark_clock_monitor_pkg;

   localparam int unsigned FC_W    = 2;
   localparam int unsigned STATE_W = 2;

   typedef logic [FC_W-1:0]    fcode_t;
   typedef logic [STATE_W-1:0] state_t;

   localparam logic [1:0] FC_NONE  = 2'b00;
   localparam logic [1:0] FC_STALL = 2'b01;
   localparam logic [1:0] FC_SHORT = 2'b10;
   localparam logic [1:0] FC_LONG  = 2'b11;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACQ    = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;
   localparam logic [1:0] ST_FAULT  = 2'd3;

endpackage : mark_clock_monitor_pkg

// File: rtl/mark_clock_monitor_if.sv
// Signal bundle between the clock monitor and whatever drives/observes it.
interface mark_clock_monitor_if #(
   parameter int unsigned CNT_W = 16
) ();
   logic             mon_clk;
   logic             clr_fault;
   logic [CNT_W-1:0] half_period;
   logic             period_valid;
   logic             locked;
   logic             fault;
   logic [1:0]       fault_code;
   logic [31:0]      edge_count;

   modport master (
      output mon_clk, clr_fault,
      input  half_period, period_valid, locked, fault, fault_code, edge_count
   );

   modport slave (
      input  mon_clk, clr_fault,
      output half_period, period_valid, locked, fault, fault_code, edge_count
   );
endinterface : mark_clock_monitor_if

// File: rtl/mark_clock_monitor_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level plus a both-polarity edge
// detector on the synchronized output.
module mark_sync_edge #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic level,
   output logic edge_c
);
   localparam int unsigned STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   logic [STAGES-1:0] sync;
   logic              prev;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync <= '0;
         prev <= 1'b0;
      end else begin
         sync <= {sync[STAGES-2:0], d};
         prev <= sync[STAGES-1];
      end
   end

   assign level  = sync[STAGES-1];
   assign edge_c = level ^ prev;

endmodule : mark_sync_edge

// File: rtl/mark_clock_monitor.sv
// Measures the half-period of an asynchronous strobe in clk cycles, locks after
// a run of in-tolerance half-periods and latches stall / out-of-range faults.
module mark_clock_monitor
   import mark_clock_monitor_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned EXP_HALF    = 8,
   parameter int unsigned TOL         = 1,
   parameter int unsigned LOCK_COUNT  = 4,
   parameter int unsigned STALL_LIMIT = 64
) (
   input logic                 clk,
   input logic                 reset,
   mark_clock_monitor_if.slave bus
);
   localparam int unsigned GOOD_W = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT + 1) : 1;
   // Signed bounds so a tolerance larger than the expectation cannot wrap.
   localparam int LO = int'(EXP_HALF) - int'(TOL);
   localparam int HI = int'(EXP_HALF) + int'(TOL);

   logic edge_c;
   logic unused_level;

   mark_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
      .clk    (clk),
      .reset  (reset),
      .d      (bus.mon_clk),
      .level  (unused_level),
      .edge_c (edge_c)
   );

   logic [CNT_W-1:0]  cnt;
   logic [CNT_W:0]    meas_c;
   logic signed [31:0] meas_s_c;
   logic              in_range_c;
   logic              stall_c;

   assign meas_c     = {1'b0, cnt} + (CNT_W+1)'(1);
   assign meas_s_c   = $signed(32'(meas_c));
   assign in_range_c = (meas_s_c >= LO) && (meas_s_c <= HI);
   assign stall_c    = !edge_c && (cnt == CNT_W'(STALL_LIMIT));

   // Cycles since the last detected edge, saturating at the stall limit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (edge_c) begin
         cnt <= '0;
      end else if (cnt != CNT_W'(STALL_LIMIT)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   logic [STATE_W-1:0] state, state_n;
   logic [GOOD_W-1:0]  good, good_n;
   logic [GOOD_W:0]    good_inc_c;
   logic               lock_hit_c;
   logic [CNT_W-1:0]   half_r, half_n;
   logic               pv_r, pv_n;
   logic               locked_r;
   logic               fault_r, fault_n;
   logic [FC_W-1:0]    code_r, code_n;
   logic [31:0]        ecount_r;

   assign good_inc_c = {1'b0, good} + (GOOD_W+1)'(1);
   assign lock_hit_c = (good_inc_c == (GOOD_W+1)'(LOCK_COUNT));

   // Next-state and registered-output decode.
   always_comb begin
      state_n = state;
      good_n  = good;
      half_n  = half_r;
      pv_n    = 1'b0;
      fault_n = fault_r;
      code_n  = code_r;
      case (state)
         ST_IDLE: begin
            if (edge_c) begin
               state_n = ST_ACQ;
               good_n  = '0;
            end
         end
         ST_ACQ: begin
            if (edge_c) begin
               half_n = CNT_W'(meas_c);
               pv_n   = 1'b1;
               if (!in_range_c) begin
                  good_n = '0;
               end else if (lock_hit_c) begin
                  state_n = ST_LOCKED;
                  good_n  = '0;
               end else begin
                  good_n = GOOD_W'(good_inc_c);
               end
            end else if (stall_c) begin
               state_n = ST_FAULT;
               fault_n = 1'b1;
               code_n  = FC_STALL;
            end
         end
         ST_LOCKED: begin
            if (edge_c) begin
               half_n = CNT_W'(meas_c);
               pv_n   = 1'b1;
               if (!in_range_c) begin
                  state_n = ST_FAULT;
                  fault_n = 1'b1;
                  code_n  = (meas_s_c < LO) ? FC_SHORT : FC_LONG;
               end
            end else if (stall_c) begin
               state_n = ST_FAULT;
               fault_n = 1'b1;
               code_n  = FC_STALL;
            end
         end
         ST_FAULT: begin
            // A clear coinciding with an edge wins; that edge is not measured.
            if (bus.clr_fault) begin
               state_n = ST_IDLE;
               good_n  = '0;
               fault_n = 1'b0;
               code_n  = FC_NONE;
            end else if (edge_c) begin
               half_n = CNT_W'(meas_c);
               pv_n   = 1'b1;
            end
         end
         default: begin
            state_n = ST_IDLE;
            good_n  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         good     <= '0;
         half_r   <= '0;
         pv_r     <= 1'b0;
         locked_r <= 1'b0;
         fault_r  <= 1'b0;
         code_r   <= FC_NONE;
      end else begin
         state    <= state_n;
         good     <= good_n;
         half_r   <= half_n;
         pv_r     <= pv_n;
         locked_r <= (state_n == ST_LOCKED);
         fault_r  <= fault_n;
         code_r   <= code_n;
      end
   end

   // Edges are counted in every state, including across a fault clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ecount_r <= '0;
      end else if (edge_c) begin
         ecount_r <= ecount_r + 32'd1;
      end
   end

   assign bus.half_period  = half_r;
   assign bus.period_valid = pv_r;
   assign bus.locked       = locked_r;
   assign bus.fault        = fault_r;
   assign bus.fault_code   = code_r;
   assign bus.edge_count   = ecount_r;

endmodule : mark_clock_monitor

// File: tb/tb_mark_clock_monitor.sv
// Directed bench for mark_clock_monitor: a table of toggle gaps with expected
// monitor outputs, plus hand sequences for idle, stall, clear and reset cases.
module tb_mark_clock_monitor;
   import mark_clock_monitor_pkg::*;

   localparam int unsigned CNT_W = 16;

   logic clk;
   logic reset;

   mark_clock_monitor_if #(.CNT_W(CNT_W)) bus ();

   mark_clock_monitor #(
      .SYNC_STAGES (2),
      .CNT_W       (CNT_W),
      .EXP_HALF    (8),
      .TOL         (1),
      .LOCK_COUNT  (4),
      .STALL_LIMIT (64)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   int total = 0;
   int bad   = 0;
   int n_tog = 0;
   int pv_seen;
   logic [CNT_W-1:0] pv_half;

   typedef struct {
      int         gap;
      int         pv;
      int         half;
      logic       locked;
      logic       fault;
      logic [1:0] code;
   } vec_t;

   vec_t vt [11];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   // Called just after a posedge; holds reset for 3 clk with mon_clk low.
   task automatic do_reset();
      reset         = 1'b1;
      bus.mon_clk   = 1'b0;
      bus.clr_fault = 1'b0;
      n_tog         = 0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Toggle mon_clk now, then wait h clk cycles, counting period_valid pulses.
   task automatic tog_wait(input int h);
      bus.mon_clk = ~bus.mon_clk;
      n_tog++;
      pv_seen = 0;
      for (int i = 0; i < h; i++) begin
         @(negedge clk);
         if (bus.period_valid) begin
            pv_seen++;
            pv_half = bus.half_period;
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic lock_up();
      do_reset();
      for (int i = 0; i < 5; i++) tog_wait(8);
      chk("lockup_locked", 32'(bus.locked), 32'd1);
   endtask

   initial begin
      reset         = 1'b1;
      bus.mon_clk   = 1'b0;
      bus.clr_fault = 1'b0;
      vt[0]  = '{8,  0, 0,  1'b0, 1'b0, FC_NONE};
      vt[1]  = '{8,  1, 8,  1'b0, 1'b0, FC_NONE};
      vt[2]  = '{8,  1, 8,  1'b0, 1'b0, FC_NONE};
      vt[3]  = '{8,  1, 8,  1'b0, 1'b0, FC_NONE};
      vt[4]  = '{7,  1, 8,  1'b1, 1'b0, FC_NONE};
      vt[5]  = '{9,  1, 7,  1'b1, 1'b0, FC_NONE};
      vt[6]  = '{8,  1, 9,  1'b1, 1'b0, FC_NONE};
      vt[7]  = '{5,  1, 8,  1'b1, 1'b0, FC_NONE};
      vt[8]  = '{8,  1, 5,  1'b0, 1'b1, FC_SHORT};
      vt[9]  = '{12, 1, 8,  1'b0, 1'b1, FC_SHORT};
      vt[10] = '{8,  1, 12, 1'b0, 1'b1, FC_SHORT};

      @(posedge clk);
      #1;
      do_reset();
      chk("rst_half",   32'(bus.half_period),  32'd0);
      chk("rst_pv",     32'(bus.period_valid), 32'd0);
      chk("rst_locked", 32'(bus.locked),       32'd0);
      chk("rst_fault",  32'(bus.fault),        32'd0);
      chk("rst_code",   32'(bus.fault_code),   32'(FC_NONE));
      chk("rst_ecount", bus.edge_count,        32'd0);
      chk("rst_state",  32'(dut.state),        32'(ST_IDLE));

      // Toggle-gap table: the row's edge measures the previous row's gap.
      for (int r = 0; r < 11; r++) begin
         tog_wait(vt[r].gap);
         chk($sformatf("vec%0d_pv", r),     32'(pv_seen),          32'(vt[r].pv));
         chk($sformatf("vec%0d_half", r),   32'(bus.half_period),  32'(vt[r].half));
         chk($sformatf("vec%0d_locked", r), 32'(bus.locked),       32'(vt[r].locked));
         chk($sformatf("vec%0d_fault", r),  32'(bus.fault),        32'(vt[r].fault));
         chk($sformatf("vec%0d_code", r),   32'(bus.fault_code),   32'(vt[r].code));
         chk($sformatf("vec%0d_ecount", r), bus.edge_count,        32'(r + 1));
      end

      // Held clock after reset: no edges and no stall fault.
      do_reset();
      repeat (200) @(posedge clk);
      #1;
      chk("idle_state",  32'(dut.state),     32'(ST_IDLE));
      chk("idle_fault",  32'(bus.fault),     32'd0);
      chk("idle_locked", 32'(bus.locked),    32'd0);
      chk("idle_ecount", bus.edge_count,     32'd0);

      // One long half-period while locked.
      lock_up();
      tog_wait(12);
      tog_wait(8);
      chk("long_half",  32'(bus.half_period), 32'd12);
      chk("long_fault", 32'(bus.fault),       32'd1);
      chk("long_code",  32'(bus.fault_code),  32'(FC_LONG));

      // Stall: edge seen 2 cycles after the toggle, counter zero from the 3rd,
      // reaches 64 on the 67th and the fault registers on the 68th posedge.
      lock_up();
      repeat (59) @(posedge clk);
      #1;
      chk("stall_early_fault", 32'(bus.fault), 32'd0);
      @(posedge clk);
      #1;
      chk("stall_fault",  32'(bus.fault),      32'd1);
      chk("stall_code",   32'(bus.fault_code), 32'(FC_STALL));
      chk("stall_locked", 32'(bus.locked),     32'd0);

      // Clear coinciding with the detected edge of a toggle.
      bus.mon_clk = ~bus.mon_clk;
      n_tog++;
      @(posedge clk);
      @(posedge clk);
      #1 bus.clr_fault = 1'b1;
      @(posedge clk);
      #1 bus.clr_fault = 1'b0;
      chk("clr_state",  32'(dut.state),        32'(ST_IDLE));
      chk("clr_fault",  32'(bus.fault),        32'd0);
      chk("clr_code",   32'(bus.fault_code),   32'(FC_NONE));
      chk("clr_pv",     32'(bus.period_valid), 32'd0);
      chk("clr_ecount", bus.edge_count,        32'(n_tog));
      repeat (5) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) tog_wait(8);
      chk("clr_relock4", 32'(bus.locked), 32'd0);
      tog_wait(8);
      chk("clr_relock5", 32'(bus.locked), 32'd1);
      chk("clr_relock_ecount", bus.edge_count, 32'(n_tog));

      // Asynchronous reset while locked, checked before the next clk edge.
      lock_up();
      @(posedge clk);
      #2 reset = 1'b1;
      bus.mon_clk = 1'b0;
      #1;
      chk("arst_half",   32'(bus.half_period),  32'd0);
      chk("arst_pv",     32'(bus.period_valid), 32'd0);
      chk("arst_locked", 32'(bus.locked),       32'd0);
      chk("arst_fault",  32'(bus.fault),        32'd0);
      chk("arst_code",   32'(bus.fault_code),   32'(FC_NONE));
      chk("arst_ecount", bus.edge_count,        32'd0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      n_tog = 0;
      for (int i = 0; i < 4; i++) tog_wait(8);
      chk("arst_relock4", 32'(bus.locked), 32'd0);
      tog_wait(8);
      chk("arst_relock5", 32'(bus.locked), 32'd1);
      chk("arst_ecount5", bus.edge_count,  32'd5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_mark_clock_monitor

// File: doc/mark_clock_monitor.md
Name: mark_clock_monitor

Overview:
- Checker-side counterpart to the testbench clock model.
- Samples a monitored clock-like signal (mon_clk) as data in the clk domain.
- Measures its half-period in clk cycles, declares lock after N in-tolerance half-periods, and flags stall or out-of-range faults.
- Used in Golomb-ruler search benches and on-chip to confirm that the mark-step clock or strobe actually runs after reset release.

Parameters:
SYNC_STAGES, 2, synchronizer depth for mon_clk (minimum 2)
CNT_W, 16, width of the half-period counter and the half_period output
EXP_HALF, 8, expected half-period in clk cycles
TOL, 1, allowed absolute deviation from EXP_HALF
LOCK_COUNT, 4, consecutive in-tolerance half-periods required to lock
STALL_LIMIT, 64, clk cycles without an edge that count as a stall (must be < 2^CNT_W - 1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-high reset
mon_clk  input  1  monitored signal; asynchronous to clk
clr_fault  input  1  single-cycle pulse; clears a sticky fault and restarts acquisition
half_period  output  CNT_W  last measured half-period in clk cycles
period_valid  output  1  one-cycle pulse when half_period updates
locked  output  1  high while in LOCKED
fault  output  1  sticky fault flag
fault_code  output  2  00 none, 01 stall, 10 too short, 11 too long
edge_count  output  32  total mon_clk edges detected (both polarities), wraps at 2^32

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high. All flops reset asynchronously.
- Reset values: sync chain 0, previous-sample 0, counter 0, state IDLE, half_period 0, period_valid 0, locked 0, fault 0, fault_code 00, edge_count 0.
- Synchronizer and edge detect:
  - mon_clk passes through SYNC_STAGES flops.
  - edge = sync_out XOR prev. Either polarity counts as an edge.
  - Detection latency is SYNC_STAGES+1 clk cycles. It is constant, so measurements are unaffected.
- Counter cnt:
  - Clears to 0 on edge; otherwise increments each cycle.
  - Saturates at STALL_LIMIT.
  - Measured value at an edge is meas = cnt+1, computed at CNT_W+1 bits with no wrap.
- In range: EXP_HALF-TOL <= meas <= EXP_HALF+TOL. Compare signed so that EXP_HALF<TOL does not underflow.
- edge_count increments on every edge in every state, including FAULT.
- FSM states: IDLE, ACQ, LOCKED, FAULT.
  - IDLE:
    - First edge -> ACQ, with good_cnt=0 and no measurement (no prior reference).
    - Stall is ignored in IDLE, so a clock held in reset is not a fault.
  - ACQ, on each edge:
    - half_period<=meas and period_valid=1 for the next cycle.
    - In range: good_cnt++. When good_cnt reaches LOCK_COUNT -> LOCKED.
    - Out of range: good_cnt<=0 and stay in ACQ. No fault before lock.
    - Stall (cnt==STALL_LIMIT with no edge) -> FAULT, code 01.
  - LOCKED, on each edge:
    - half_period and period_valid update as in ACQ.
    - Out of range -> FAULT, code 10 if meas<EXP_HALF-TOL, else 11.
    - Stall -> FAULT, code 01.
    - locked=1 while in this state.
  - FAULT:
    - fault=1; fault_code holds its value; locked=0.
    - Measurements continue to update half_period and period_valid.
    - clr_fault -> IDLE with fault=0, code 00, good_cnt=0.
- Simultaneous events:
  - clr_fault together with edge: the clear wins and the edge is not measured (edge_count still increments).
  - Stall and edge in the same cycle: the edge wins, no stall.
  - clr_fault outside FAULT is ignored.
- Reset mid-operation returns every register to its reset value immediately; the next edge after release is treated as the first edge.

Decomposition:
- Shared package/header: the fault_code encodings (FC_NONE, FC_STALL, FC_SHORT, FC_LONG) and the FSM state encodings, so bench checkers can decode them.
- One natural sub-module: mark_sync_edge (SYNC_STAGES synchronizer plus edge detect, outputs the synchronized level and an edge pulse).
- The counter, FSM and range check stay in the top module.

Test Plan:
- Defaults; reset released; mon_clk toggles every 8 clk -> first period_valid with half_period=8; locked=1 after the 5th edge (first edge plus 4 good); fault=0; edge_count tracks toggles exactly.
- mon_clk held at 0 for 200 clk after reset -> state stays IDLE, fault=0, locked=0, edge_count=0.
- Locked at 8, then mon_clk stops -> exactly 64 cycles after the last edge, fault=1, fault_code=01, locked=0.
- Locked, then one half-period of 5 -> fault_code=10. Separate run with one half-period of 12 -> fault_code=11. Half-periods of 7 and 9 keep locked=1.
- In FAULT, pulse clr_fault in the same cycle as a detected edge -> state IDLE, fault=0, code 00, no period_valid; resumes and relocks after 5 further edges at 8.
- Assert reset for 3 clk while locked -> all outputs return to reset values asynchronously (check before the next clk edge); after release, relock takes 5 edges.
